// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants and parser state encoding for the SDRAM image loader.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         OFFSET_W   = 15;
  localparam int         RAM_ADDR_W = 23;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_ADR_HI,
    ST_ADR_LO,
    ST_DATA,
    ST_CSUM,
    ST_DRAIN,
    ST_DONE,
    ST_ERROR
  } state_t;

  // States in which the inter-byte idle timeout is armed.
  function automatic logic in_packet(input state_t s);
    return s inside {ST_LEN_HI, ST_LEN_LO, ST_ADR_HI, ST_ADR_LO, ST_DATA, ST_CSUM};
  endfunction

endpackage

// File: rtl/loader_fifo.sv
// rtl/loader_fifo.sv - synchronous DEPTH x WIDTH byte FIFO between the parser and the SDRAM writer.
module loader_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_image_loader.sv
// rtl/sdram_image_loader.sv - parses framed image packets from the UART byte stream and writes them to SDRAM.
// Define SDRAM_IMAGE_LOADER_CHECKSUM_EN to expect and verify a trailing checksum byte.
module sdram_image_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] BANK           = 8'd1,
  parameter int         FIFO_DEPTH     = 4,
  parameter int         TIMEOUT_CYCLES = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  new_rx_data,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [7:0]            ram_data,
  output logic                  ram_rw,
  output logic                  in_valid,
  input  logic                  busy,
  output logic                  image_ready,
  output logic                  load_error,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_t               state;
  state_t               state_next;
  logic [7:0]           len_hi;
  logic [15:0]          remain;
  logic [6:0]           adr_hi;
  logic [OFFSET_W-1:0]  offset;
  logic [TO_W-1:0]      idle_cnt;
  logic                 pend_sync;
  logic                 pkt_ovf;
`ifdef SDRAM_IMAGE_LOADER_CHECKSUM_EN
  logic [7:0]           sum;
`endif

  logic                 push;
  logic                 pop;
  logic                 drop;
  logic [7:0]           fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic                 rx_sync;
  logic                 timeout;

  loader_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rx_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign ram_rw  = 1'b0;
  assign rx_sync = new_rx_data && (rx_data == SYNC_BYTE);
  assign timeout = in_packet(state) && !new_rx_data && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = ST_ERROR;
    end else begin
      case (state)
        ST_IDLE:   if (rx_sync) state_next = ST_LEN_HI;
        // DONE and ERROR are resting states; a sync seen during DRAIN starts here.
        ST_DONE,
        ST_ERROR:  if (rx_sync || pend_sync) state_next = ST_LEN_HI;
        ST_LEN_HI: if (new_rx_data) state_next = ST_LEN_LO;
        ST_LEN_LO: if (new_rx_data) state_next = ({len_hi, rx_data} == 16'd0) ? ST_ERROR : ST_ADR_HI;
        ST_ADR_HI: if (new_rx_data) state_next = ST_ADR_LO;
        ST_ADR_LO: if (new_rx_data) state_next = ST_DATA;
        ST_DATA: begin
          if (new_rx_data && remain == 16'd1) begin
`ifdef SDRAM_IMAGE_LOADER_CHECKSUM_EN
            state_next = ST_CSUM;
`else
            state_next = ST_DRAIN;
`endif
          end
        end
`ifdef SDRAM_IMAGE_LOADER_CHECKSUM_EN
        ST_CSUM:   if (new_rx_data) state_next = (rx_data == sum) ? ST_DRAIN : ST_ERROR;
`endif
        ST_DRAIN:  if (fifo_count == '0 && !in_valid) state_next = pkt_ovf ? ST_ERROR : ST_DONE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    image_ready = (state == ST_DONE);
    load_error  = (state == ST_ERROR);
    pop         = !fifo_empty && !busy && !in_valid;
    push        = new_rx_data && (state == ST_DATA) && (!fifo_full || pop);
    drop        = new_rx_data && (state == ST_DATA) && fifo_full && !pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi    <= '0;
      remain    <= '0;
      adr_hi    <= '0;
      offset    <= '0;
      idle_cnt  <= '0;
      pend_sync <= 1'b0;
      pkt_ovf   <= 1'b0;
      overflow  <= 1'b0;
      in_valid  <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
`ifdef SDRAM_IMAGE_LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      in_valid <= pop;
      if (pop) begin
        ram_addr <= {BANK, offset};
        ram_data <= fifo_dout;
      end

      if (new_rx_data || !in_packet(state)) idle_cnt <= '0;
      else                                  idle_cnt <= idle_cnt + TO_W'(1);

      if (state == ST_DRAIN && rx_sync)   pend_sync <= 1'b1;
      else if (state_next == ST_LEN_HI)   pend_sync <= 1'b0;

      if (new_rx_data && state == ST_ADR_LO) offset <= {adr_hi, rx_data};
      else if (pop)                          offset <= offset + OFFSET_W'(1);

      if (new_rx_data) begin
        case (state)
          ST_LEN_HI: len_hi <= rx_data;
          ST_LEN_LO: remain <= {len_hi, rx_data};
          ST_ADR_HI: adr_hi <= rx_data[6:0];
          ST_ADR_LO: begin
            pkt_ovf <= 1'b0;
`ifdef SDRAM_IMAGE_LOADER_CHECKSUM_EN
            sum     <= '0;
`endif
          end
          ST_DATA: begin
            remain <= remain - 16'd1;
`ifdef SDRAM_IMAGE_LOADER_CHECKSUM_EN
            sum    <= sum + rx_data;
`endif
            if (drop) begin
              overflow <= 1'b1;
              pkt_ovf  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_image_loader.sv
// tb/tb_sdram_image_loader.sv - directed, table-driven bench for sdram_image_loader.
module tb_sdram_image_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        new_rx_data = 1'b0;
  logic [22:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_rw;
  logic        in_valid;
  logic        busy = 1'b0;
  logic        image_ready;
  logic        load_error;
  logic        overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc;
  int qs;
  logic [30:0] wr_q[$];
  logic        prev_iv = 1'b0;

  typedef struct {
    logic [14:0] off;
    int          len;
    logic [47:0] data;
    logic [7:0]  csum;
    bit          csum_only;
    bit          hold_busy;
    int          n_wr;
    logic [22:0] addr0;
    bit          ready;
    bit          err;
    bit          ovf;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  sdram_image_loader #(.BANK(8'd1), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(100)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .ram_addr    (ram_addr),
    .ram_data    (ram_data),
    .ram_rw      (ram_rw),
    .in_valid    (in_valid),
    .busy        (busy),
    .image_ready (image_ready),
    .load_error  (load_error),
    .overflow    (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (in_valid) begin
      chk("in_valid_spacing", 32'(prev_iv), 32'd0);
      wr_q.push_back({ram_addr, ram_data});
    end
    prev_iv <= in_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data     = b;
    new_rx_data = 1'b1;
    tick();
    new_rx_data = 1'b0;
  endtask

  // ADR_HI bit 7 is set on purpose: the loader must ignore it.
  task automatic send_hdr(input logic [15:0] len, input logic [14:0] off);
    send_byte(8'hA5);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    send_byte({1'b1, off[14:8]});
    send_byte(off[7:0]);
  endtask

  task automatic run_vec(input int i);
    logic [14:0] lo;
    vec_t v;
    v = vecs[i];
    busy = v.hold_busy;
    send_hdr(16'(v.len), v.off);
    for (int j = 0; j < v.len; j++) send_byte(v.data[47-8*j -: 8]);
`ifdef SDRAM_IMAGE_LOADER_CHECKSUM_EN
    send_byte(v.csum);
`endif
    busy = 1'b0;
    for (cyc = 1; cyc <= 300; cyc++) begin
      if (image_ready || load_error) break;
      tick();
    end
    chk($sformatf("v%0d_complete", i), 32'(cyc <= 300), 32'd1);
    repeat (12) tick();
    chk($sformatf("v%0d_nwrites", i), 32'(wr_q.size()), 32'(v.n_wr));
    for (int j = 0; j < v.n_wr && j < wr_q.size(); j++) begin
      lo = v.addr0[14:0] + 15'(j);
      chk($sformatf("v%0d_write%0d", i, j), 32'(wr_q[j]), 32'({v.addr0[22:15], lo, v.data[47-8*j -: 8]}));
    end
    chk($sformatf("v%0d_image_ready", i), 32'(image_ready), 32'(v.ready));
    chk($sformatf("v%0d_load_error", i), 32'(load_error), 32'(v.err));
    chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(v.ovf));
    wr_q.delete();
  endtask

  initial begin
    vecs[0] = '{15'h4000, 3, 48'h112233000000, 8'h66, 1'b0, 1'b0, 3, 23'h00C000, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{15'h4000, 3, 48'h112233000000, 8'h00, 1'b1, 1'b0, 3, 23'h00C000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{15'h7FFE, 4, 48'h010203040000, 8'h0A, 1'b0, 1'b0, 4, 23'h00FFFE, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{15'h0000, 1, 48'hA50000000000, 8'hA5, 1'b0, 1'b0, 1, 23'h008000, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{15'h0100, 6, 48'hA0A1A2A3A4A5, 8'hCF, 1'b0, 1'b1, 4, 23'h008100, 1'b0, 1'b1, 1'b1};

    rst = 1'b1;
    tick();
    tick();
    chk("reset_addr", 32'(ram_addr), 32'd0);
    chk("reset_flags", 32'({ram_data, ram_rw, in_valid, image_ready, load_error, overflow}), 32'd0);
    rst = 1'b0;
    tick();

    // LEN of zero is rejected right at LEN_LO.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("len_zero_error", 32'(load_error), 32'd1);
    chk("len_zero_ready", 32'(image_ready), 32'd0);

    // Stream stalls after ADR_LO: error exactly TIMEOUT_CYCLES later.
    send_hdr(16'd5, 15'h0010);
    for (cyc = 1; cyc <= 200; cyc++) begin
      tick();
      if (load_error) break;
    end
    chk("timeout_cycles", 32'(cyc), 32'd100);
    chk("timeout_no_write", 32'(wr_q.size()), 32'd0);
    send_byte(8'hA5);
    chk("sync_clears_error", 32'(load_error), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Reset after the second of three data bytes.
    send_hdr(16'd3, 15'h0200);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    tick();
    chk("midrst_addr", 32'(ram_addr), 32'd0);
    chk("midrst_flags", 32'({ram_data, ram_rw, in_valid, image_ready, load_error, overflow}), 32'd0);
    qs = wr_q.size();
    rst = 1'b0;
    repeat (12) tick();
    chk("midrst_no_more_writes", 32'(wr_q.size()), 32'(qs));
    wr_q.delete();

    for (int i = 0; i < 5; i++) begin
`ifndef SDRAM_IMAGE_LOADER_CHECKSUM_EN
      if (vecs[i].csum_only) continue;
`endif
      run_vec(i);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
